// File: rtl/adder_share_arb.sv
// Round-robin sequencer sharing one external W-bit adder across NREQ lanes.
// Define ADDER_SAT_EN to clip the captured sum to all ones on carry-out.
`timescale 1ns/1ps
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_sum,
  input  logic              add_co,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_co,
  output logic [IDW-1:0]    res_id
);

  logic           op_valid_q, op_valid_d;
  logic [W-1:0]   add_a_q, add_a_d;
  logic [W-1:0]   add_b_q, add_b_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic [IDW-1:0] last_q, last_d;
  logic           res_valid_q, res_valid_d;
  logic [W-1:0]   res_sum_q, res_sum_d;
  logic           res_co_q, res_co_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic           res_free, op_free, op_move;
  logic           gnt_ok, xfer;
  logic [IDW-1:0] gnt_id;
  logic [W-1:0]   cap_sum;

  assign res_free = !res_valid_q || res_ready;
  assign op_free  = !op_valid_q || res_free;
  assign op_move  = op_valid_q && res_free;

  // First valid requester searching from last+1 around the ring
  always_comb begin
    gnt_ok = 1'b0;
    gnt_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_ok && req_valid[(int'(last_q) + k) % NREQ]) begin
        gnt_ok = 1'b1;
        gnt_id = IDW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  assign xfer = gnt_ok && op_free && rst_n;

  assign req_ready = xfer
    ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id)
    : '0;

`ifdef ADDER_SAT_EN
  assign cap_sum = add_co ? {W{1'b1}} : add_sum;
`else
  assign cap_sum = add_sum;
`endif

  // Operands only change on a transfer so the adder stays quiet when idle
  always_comb begin
    op_valid_d = op_valid_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    op_id_d    = op_id_q;
    last_d     = last_q;
    if (xfer) begin
      op_valid_d = 1'b1;
      add_a_d    = req_a[int'(gnt_id)*W +: W];
      add_b_d    = req_b[int'(gnt_id)*W +: W];
      op_id_d    = gnt_id;
      last_d     = gnt_id;
    end else if (op_move) begin
      op_valid_d = 1'b0;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_co_d    = res_co_q;
    res_id_d    = res_id_q;
    if (op_move) begin
      res_valid_d = 1'b1;
      res_sum_d   = cap_sum;
      res_co_d    = add_co;
      res_id_d    = op_id_q;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q  <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      op_id_q     <= '0;
      last_q      <= IDW'(NREQ - 1);
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_co_q    <= 1'b0;
      res_id_q    <= '0;
    end else begin
      op_valid_q  <= op_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      op_id_q     <= op_id_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_co_q    <= res_co_d;
      res_id_q    <= res_id_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_co    = res_co_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed self-checking bench for adder_share_arb.
// Models the shared adder as an exact W-bit add with carry-out.
`timescale 1ns/1ps
module tb_adder_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_sum;
  logic              add_co;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_co;
  logic [IDW-1:0]    res_id;

  int total = 0;
  int bad   = 0;

  adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_co(add_co),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_co(res_co), .res_id(res_id)
  );

  always #5 clk = ~clk;

  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  task automatic set_std();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(4 * i);
      req_b[i*W +: W] = 16'd8;
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_std();
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #12;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=0000", req_ready);
    end
    total++;
    if ({add_a, add_b} !== 32'h0) begin
      bad++;
      $display("FAIL rst_add got=%h exp=0", {add_a, add_b});
    end
    total++;
    if ({res_valid, res_co, res_id, res_sum} !== 20'h0) begin
      bad++;
      $display("FAIL rst_res got=%h exp=0",
               {res_valid, res_co, res_id, res_sum});
    end
  endtask

  task automatic test_single();
    do_reset();
    req_a[2*W +: W] = 16'd16;
    req_b[2*W +: W] = 16'd12;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    total++;
    if (add_a !== 16'd16 || add_b !== 16'd12 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_op got=%0d/%0d/%b exp=16/12/0",
               add_a, add_b, res_valid);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_sum !== 16'd28 ||
        res_id !== 2'd2 || res_co !== 1'b0) begin
      bad++;
      $display("FAIL single_res got=%b/%0d/%0d/%b exp=1/28/2/0",
               res_valid, res_sum, res_id, res_co);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0 || add_a !== 16'd16) begin
      bad++;
      $display("FAIL single_hold got=%b/%0d exp=0/16", res_valid, add_a);
    end
    set_std();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int eid;
    do_reset();
    set_std();
    req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      total++;
      if (req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp_rdy);
      end
      if (k >= 2) begin
        eid = (k - 2) % 4;
        total++;
        if (res_valid !== 1'b1 || res_id !== IDW'(eid) ||
            res_sum !== W'(4 * eid + 8)) begin
          bad++;
          $display("FAIL rr_res k=%0d got=%b/%0d/%0d exp=1/%0d/%0d",
                   k, res_valid, res_id, res_sum, eid, 4 * eid + 8);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n = 0;
    int eid;
    do_reset();
    set_std();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready !== 4'b0000) n++;
      @(negedge clk);
    end
    #1;
    total++;
    if (n !== 2 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL bp_accept got=%0d/%b exp=2/0000", n, req_ready);
    end
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_sum !== 16'd8) begin
      bad++;
      $display("FAIL bp_hold got=%b/%0d/%0d exp=1/0/8",
               res_valid, res_id, res_sum);
    end
    res_ready = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      @(negedge clk);
      eid = m % 4;
      total++;
      if (res_valid !== 1'b1 || res_id !== IDW'(eid) ||
          res_sum !== W'(4 * eid + 8)) begin
        bad++;
        $display("FAIL bp_drain m=%0d got=%b/%0d/%0d exp=1/%0d/%0d",
                 m, res_valid, res_id, res_sum, eid, 4 * eid + 8);
      end
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_sum;
`ifdef ADDER_SAT_EN
    exp_sum = 16'hFFFF;
`else
    exp_sum = 16'h0010;
`endif
    do_reset();
    req_a[0 +: W] = 16'hFFF0;
    req_b[0 +: W] = 16'h0020;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_co !== 1'b1 || res_sum !== exp_sum) begin
      bad++;
      $display("FAIL ovf got=%b/%b/%h exp=1/1/%h",
               res_valid, res_co, res_sum, exp_sum);
    end
    set_std();
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_std();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || req_ready !== 4'b0000 || add_a !== 16'd4) begin
      bad++;
      $display("FAIL mid_full got=%b/%b/%0d exp=1/0000/4",
               res_valid, req_ready, add_a);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0000 || add_a !== 16'd0 || add_b !== 16'd0 ||
        res_valid !== 1'b0 || res_sum !== 16'd0 ||
        res_co !== 1'b0 || res_id !== 2'd0) begin
      bad++;
      $display("FAIL mid_rst got=%b/%h/%h/%b/%h/%b/%0d exp=all zero",
               req_ready, add_a, add_b, res_valid, res_sum, res_co, res_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_first got=%b exp=0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_held();
    do_reset();
    set_std();
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL held_r0 got=%b exp=0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL held_r1 got=%b exp=0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL held_back got=%b exp=0001", req_ready);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== 16'd12) begin
      bad++;
      $display("FAIL held_res got=%b/%0d/%0d exp=1/1/12",
               res_valid, res_id, res_sum);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    test_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
